// File: rtl/bus_route_arbiter.sv
// bus_route_arbiter: round-robin bus-switch route arbiter with endpoint reservation; BUS_ROUTE_ARBITER_MALFORMED_DROP_EN enables dropping malformed routes
module bus_route_arbiter #(
    parameter int N = 4,
    parameter int R = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R*2*N-1:0] req,
    input  logic [R-1:0]     req_isReady,
    output logic [R-1:0]     req_canReceive,
    output logic [2*N-1:0]   cmd,
    output logic             cmd_isReady,
    input  logic             cmd_canReceive,
    input  logic [N-1:0]     src_isLast,
    output logic [N-1:0]     busy,
    output logic             err
);
    localparam int PW = R > 1 ? $clog2(R) : 1;
    localparam int SW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr, gnt_idx;
    logic [R-1:0]  elig, bad;
    logic          found, free, drop, issue;
    logic [N-1:0]  src_f [R];
    logic [N-1:0]  dst_f [R];
    logic [N-1:0]  route_tbl [N];
    logic [N-1:0]  rel_mask, gnt_src, gnt_mask;
    logic [SW-1:0] gnt_slot;
`ifdef BUS_ROUTE_ARBITER_MALFORMED_DROP_EN
    localparam bit DROP_EN = 1'b1;
    assign drop = found && bad[gnt_idx];
    always_ff @(posedge clk) err <= rst ? 1'b0 : err | (free && drop);
`else
    localparam bit DROP_EN = 1'b0;
    assign drop = 1'b0;
    assign err = 1'b0;
`endif
    for (genvar i = 0; i < R; i++) begin : g_req
        assign src_f[i] = req[i*2*N +: N];
        assign dst_f[i] = req[i*2*N+N +: N];
        assign bad[i]   = !$onehot(src_f[i]) || dst_f[i] == '0;
        assign elig[i]  = req_isReady[i] && (bad[i] ? DROP_EN : ((src_f[i] | dst_f[i]) & busy) == '0);
    end
    always_comb begin
        found = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < R; k++) begin
            if (!found && elig[(int'(ptr) + k) % R]) begin
                found = 1'b1;
                gnt_idx = PW'((int'(ptr) + k) % R);
            end
        end
    end
    assign free = !cmd_isReady || cmd_canReceive;
    assign issue = free && found && !drop;
    assign req_canReceive = (!rst && free && found) ? R'(1) << gnt_idx : '0;
    assign gnt_src = src_f[gnt_idx];
    assign gnt_mask = src_f[gnt_idx] | dst_f[gnt_idx];
    // a route is remembered under the lowest set bit of its source mask
    always_comb begin
        gnt_slot = '0;
        for (int s = N - 1; s >= 0; s--)
            if (gnt_src[s]) gnt_slot = SW'(s);
    end
    always_comb begin
        rel_mask = '0;
        for (int s = 0; s < N; s++)
            if (src_isLast[s] && busy[s]) rel_mask = rel_mask | route_tbl[s];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cmd <= '0;
            cmd_isReady <= 1'b0;
            busy <= '0;
            for (int s = 0; s < N; s++) route_tbl[s] <= '0;
        end else begin
            if (free) cmd_isReady <= issue;
            if (issue) cmd <= {dst_f[gnt_idx], src_f[gnt_idx]};
            if (free && found) ptr <= gnt_idx == PW'(R - 1) ? '0 : gnt_idx + PW'(1);
            busy <= (busy & ~rel_mask) | (issue ? gnt_mask : '0);
            for (int s = 0; s < N; s++)
                route_tbl[s] <= (issue && gnt_slot == SW'(s)) ? gnt_mask :
                                (src_isLast[s] && busy[s]) ? '0 : route_tbl[s];
        end
    end
endmodule

// File: tb/tb_bus_route_arbiter.sv
// tb_bus_route_arbiter: directed vector table plus randomized run against a route-list reference model
module tb_bus_route_arbiter;
    localparam int N = 4;
    localparam int R = 4;
`ifdef BUS_ROUTE_ARBITER_MALFORMED_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    logic [R*2*N-1:0] req;
    logic [R-1:0] req_isReady, req_canReceive;
    logic [2*N-1:0] cmd;
    logic cmd_isReady, cmd_canReceive;
    logic [N-1:0] src_isLast, busy;
    logic err;
    always #5 clk = ~clk;
    bus_route_arbiter #(.N(N), .R(R)) dut (
        .clk(clk), .rst(rst), .req(req), .req_isReady(req_isReady),
        .req_canReceive(req_canReceive), .cmd(cmd), .cmd_isReady(cmd_isReady),
        .cmd_canReceive(cmd_canReceive), .src_isLast(src_isLast), .busy(busy), .err(err)
    );
    typedef struct {
        bit rs; logic [31:0] rq; logic [3:0] rd; bit cc; logic [3:0] la;
        logic [3:0] g; logic [7:0] cm; bit vl; logic [3:0] bu; bit er;
    } row_t;
    typedef struct { int slot; logic [3:0] mask; } route_t;
    row_t vec[$];
    route_t m_routes[$];
    int m_ptr;
    logic [7:0] m_cmd;
    bit m_vld, m_err;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic row_t mk(bit rs, logic [31:0] rq, logic [3:0] rd, bit cc, logic [3:0] la,
                                logic [3:0] g, logic [7:0] cm, bit vl, logic [3:0] bu, bit er);
        row_t r;
        r.rs = rs; r.rq = rq; r.rd = rd; r.cc = cc; r.la = la;
        r.g = g; r.cm = cm; r.vl = vl; r.bu = bu; r.er = er;
        return r;
    endfunction

    function automatic logic [3:0] m_busy();
        logic [3:0] b = '0;
        foreach (m_routes[i]) b |= m_routes[i].mask;
        return b;
    endfunction

    // Reference: busy is the union of live routes; a route dies when its source reports last.
    task automatic model_step(input bit r_rst, input logic [31:0] r_req, input logic [3:0] r_rdy,
                              input bit r_ccr, input logic [3:0] r_last, output logic [3:0] g);
        logic [3:0] bsy, s, d;
        bit fr, good;
        int win;
        g = '0;
        if (r_rst) begin
            m_routes.delete();
            m_ptr = 0; m_cmd = '0; m_vld = 0; m_err = 0;
            return;
        end
        bsy = m_busy();
        fr = !m_vld || r_ccr;
        win = -1;
        if (fr)
            for (int k = 0; k < R; k++) begin
                int r = (m_ptr + k) % R;
                s = r_req[r*8 +: 4];
                d = r_req[r*8+4 +: 4];
                good = $countones(s) == 1 && d != 0;
                if (win < 0 && r_rdy[r] && (good ? ((s | d) & bsy) == 0 : DROP)) win = r;
            end
        for (int i = m_routes.size() - 1; i >= 0; i--)
            if (r_last[m_routes[i].slot]) m_routes.delete(i);
        if (win >= 0) begin
            g[win] = 1'b1;
            m_ptr = (win + 1) % R;
            s = r_req[win*8 +: 4];
            d = r_req[win*8+4 +: 4];
            if ($countones(s) == 1 && d != 0) begin
                route_t nr;
                for (int i = 0; i < N; i++) if (s[i]) nr.slot = i;
                nr.mask = s | d;
                m_routes.push_back(nr);
                m_cmd = r_req[win*8 +: 8];
                m_vld = 1;
            end else begin
                m_err = 1;
                m_vld = 0;
            end
        end else if (fr) m_vld = 0;
    endtask

    initial begin
        logic [3:0] eg;
        logic [31:0] rq;
        logic [3:0] s, d;
        // single grant / latency
        vec.push_back(mk(1, 32'h0, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h41, 4'h1, 1, 4'h0, 4'h1, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h41, 4'h0, 1, 4'h0, 4'h0, 8'h41, 1, 4'h5, 0));
        // conflict, release, release/grant same cycle
        vec.push_back(mk(1, 32'h0, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h4141, 4'h3, 1, 4'h0, 4'h1, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h4141, 4'h2, 1, 4'h0, 4'h0, 8'h41, 1, 4'h5, 0));
        vec.push_back(mk(0, 32'h4141, 4'h2, 1, 4'h1, 4'h0, 8'h41, 0, 4'h5, 0));
        vec.push_back(mk(0, 32'h4141, 4'h2, 1, 4'h0, 4'h2, 8'h41, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h4141, 4'h0, 1, 4'h0, 4'h0, 8'h41, 1, 4'h5, 0));
        // disjoint back-to-back grants, pointer wrap
        vec.push_back(mk(1, 32'h0, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h84002100, 4'ha, 1, 4'h0, 4'h2, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h84002100, 4'h8, 1, 4'h0, 4'h8, 8'h21, 1, 4'h3, 0));
        vec.push_back(mk(0, 32'h84002100, 4'h0, 1, 4'h0, 4'h0, 8'h84, 1, 4'hf, 0));
        vec.push_back(mk(0, 32'h84002100, 4'h0, 1, 4'h5, 4'h0, 8'h84, 0, 4'hf, 0));
        vec.push_back(mk(0, 32'h00004812, 4'h3, 1, 4'h0, 4'h1, 8'h84, 0, 4'h0, 0));
        // back-pressure hold
        vec.push_back(mk(1, 32'h0, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h8241, 4'h3, 1, 4'h0, 4'h1, 8'h00, 0, 4'h0, 0));
        for (int i = 0; i < 5; i++)
            vec.push_back(mk(0, 32'h8241, 4'h2, 0, 4'h0, 4'h0, 8'h41, 1, 4'h5, 0));
        vec.push_back(mk(0, 32'h8241, 4'h2, 1, 4'h0, 4'h2, 8'h41, 1, 4'h5, 0));
        vec.push_back(mk(0, 32'h8241, 4'h0, 1, 4'h0, 4'h0, 8'h82, 1, 4'hf, 0));
        // malformed source mask
        vec.push_back(mk(1, 32'h0, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h00430000, 4'h4, 1, 4'h0, DROP ? 4'h4 : 4'h0, 8'h00, 0, 4'h0, 0));
        vec.push_back(mk(0, 32'h00430000, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, DROP));
        vec.push_back(mk(0, 32'h00430000, 4'h0, 1, 4'h0, 4'h0, 8'h00, 0, 4'h0, DROP));
        foreach (vec[i]) begin
            @(negedge clk);
            rst = vec[i].rs; req = vec[i].rq; req_isReady = vec[i].rd;
            cmd_canReceive = vec[i].cc; src_isLast = vec[i].la;
            #1;
            chk($sformatf("row%0d grant", i), 32'(req_canReceive), 32'(vec[i].g));
            if (!vec[i].rs) begin
                chk($sformatf("row%0d cmd", i), 32'(cmd), 32'(vec[i].cm));
                chk($sformatf("row%0d cmd_isReady", i), 32'(cmd_isReady), 32'(vec[i].vl));
                chk($sformatf("row%0d busy", i), 32'(busy), 32'(vec[i].bu));
                chk($sformatf("row%0d err", i), 32'(err), 32'(vec[i].er));
            end
        end
        @(negedge clk);
        rst = 1; req_isReady = '0; src_isLast = '0;
        #1;
        model_step(1, req, req_isReady, cmd_canReceive, src_isLast, eg);
        chk("rnd reset grant", 32'(req_canReceive), 32'(eg));
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rq = '0;
            for (int r = 0; r < R; r++) begin
                s = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
                d = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                rq[r*8 +: 8] = {d, s};
            end
            rst = $urandom_range(0, 199) == 0;
            req = rq;
            req_isReady = 4'($urandom);
            cmd_canReceive = $urandom_range(0, 3) != 0;
            src_isLast = 4'($urandom) & 4'($urandom);
            #1;
            chk($sformatf("rnd%0d cmd", c), 32'(cmd), 32'(m_cmd));
            chk($sformatf("rnd%0d cmd_isReady", c), 32'(cmd_isReady), 32'(m_vld));
            chk($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_busy()));
            chk($sformatf("rnd%0d err", c), 32'(err), 32'(m_err));
            model_step(rst, req, req_isReady, cmd_canReceive, src_isLast, eg);
            chk($sformatf("rnd%0d grant", c), 32'(req_canReceive), 32'(eg));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
